vslc_7seg_scan_rx: RTL and testbench



---
 rtl/vslc_7seg_pkg.sv | 55 +++++
 rtl/vslc_7seg_scan_rx_if.sv | 23 ++
 rtl/vslc_7seg_digit_track.sv | 38 +++
 rtl/vslc_7seg_scan_rx.sv | 89 ++++++++
 tb/tb_vslc_7seg_scan_rx.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/vslc_7seg_pkg.sv
// Shared seven-segment definitions for the VSLC display link.
// Segment words are {a,b,c,d,e,f,g}, 1 = lit.
package vslc_7seg_pkg;

  localparam int SEG_W = 7;

  localparam logic [SEG_W-1:0] SEG_0 = 7'b1111110;
  localparam logic [SEG_W-1:0] SEG_1 = 7'b0110000;
  localparam logic [SEG_W-1:0] SEG_2 = 7'b1101101;
  localparam logic [SEG_W-1:0] SEG_3 = 7'b1111001;
  localparam logic [SEG_W-1:0] SEG_4 = 7'b0110011;
  localparam logic [SEG_W-1:0] SEG_5 = 7'b1011011;
  localparam logic [SEG_W-1:0] SEG_6 = 7'b1011111;
  localparam logic [SEG_W-1:0] SEG_7 = 7'b1110000;
  localparam logic [SEG_W-1:0] SEG_8 = 7'b1111111;
  localparam logic [SEG_W-1:0] SEG_9 = 7'b1111011;
  localparam logic [SEG_W-1:0] SEG_A = 7'b1110111;
  localparam logic [SEG_W-1:0] SEG_B = 7'b0011111;
  localparam logic [SEG_W-1:0] SEG_C = 7'b1001110;
  localparam logic [SEG_W-1:0] SEG_D = 7'b0111101;
  localparam logic [SEG_W-1:0] SEG_E = 7'b1001111;
  localparam logic [SEG_W-1:0] SEG_F = 7'b1000111;

  function automatic logic [SEG_W-1:0] encode7seg(input logic [3:0] nib);
    case (nib)
      4'h0: return SEG_0;
      4'h1: return SEG_1;
      4'h2: return SEG_2;
      4'h3: return SEG_3;
      4'h4: return SEG_4;
      4'h5: return SEG_5;
      4'h6: return SEG_6;
      4'h7: return SEG_7;
      4'h8: return SEG_8;
      4'h9: return SEG_9;
      4'hA: return SEG_A;
      4'hB: return SEG_B;
      4'hC: return SEG_C;
      4'hD: return SEG_D;
      4'hE: return SEG_E;
      default: return SEG_F;
    endcase
  endfunction

  // Returns {ok, nibble}; ok=0 for any pattern outside the table.
  function automatic logic [4:0] decode7seg(input logic [SEG_W-1:0] seg);
    logic [4:0] res;
    res = '0;
    for (int i = 0; i < 16; i++) begin
      if (encode7seg(4'(i)) == seg) res = {1'b1, 4'(i)};
    end
    return res;
  endfunction

endpackage

// File: rtl/vslc_7seg_scan_rx_if.sv
// Display-line bundle between a seven-segment driver and the scan receiver.
interface vslc_7seg_scan_rx_if;
  import vslc_7seg_pkg::*;

  logic [1:0]       en_in;
  logic [SEG_W-1:0] seg_in;
  logic             dp_in;
  logic [7:0]       value;
  logic [1:0]       valid;
  logic             dp_out;
  logic             upd;
  logic             seg_err;

  modport master (
    output en_in, seg_in, dp_in,
    input  value, valid, dp_out, upd, seg_err
  );

  modport slave (
    input  en_in, seg_in, dp_in,
    output value, valid, dp_out, upd, seg_err
  );
endinterface

// File: rtl/vslc_7seg_digit_track.sv
// Per-digit state: held nibble, valid flag and a saturating staleness counter.
module vslc_7seg_digit_track #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cap,
  input  logic       ok,
  input  logic [3:0] nib_in,
  output logic [3:0] nibble,
  output logic       valid
);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] T_MAX = TW'(TIMEOUT_CYCLES);

  logic [3:0]    nibble_reg;
  logic          valid_reg;
  logic [TW-1:0] tcnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nibble_reg <= '0;
      valid_reg  <= 1'b0;
      tcnt_reg   <= '0;
    end else if (cap && ok) begin
      // A good capture wins over a timeout landing on the same cycle.
      nibble_reg <= nib_in;
      valid_reg  <= 1'b1;
      tcnt_reg   <= '0;
    end else begin
      if (tcnt_reg != T_MAX) tcnt_reg <= tcnt_reg + TW'(1);
      if (cap || (tcnt_reg == T_MAX - TW'(1))) valid_reg <= 1'b0;
    end
  end

  assign nibble = nibble_reg;
  assign valid  = valid_reg;
endmodule

// File: rtl/vslc_7seg_scan_rx.sv
// Seven-segment scan receiver: synchronize, deglitch and decode two
// multiplexed digits back into a byte with per-digit validity.
module vslc_7seg_scan_rx
  import vslc_7seg_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input logic                clk,
  input logic                rst_n,
  vslc_7seg_scan_rx_if.slave bus
);
  localparam int unsigned WORD_W   = 2 + SEG_W + 1;
  localparam logic [7:0]  STAB_MAX = 8'(STABLE_CYCLES);

  logic [WORD_W-1:0] sync1_reg, sync2_reg, prev_reg;
  logic [7:0]        stab_reg, stab_next;
  logic              sel_ok, fire;
  logic              cap_reg, cap_digit_reg, cap_dp_reg;
  logic [SEG_W-1:0]  cap_seg_reg;
  logic [4:0]        dec;
  logic              upd_reg, seg_err_reg, dp_out_reg;
  logic [3:0]        nib_w [2];
  logic              valid_w [2];

  // Exactly one enable high selects a digit; 00 and 11 are blanking.
  assign sel_ok = ^sync2_reg[WORD_W-1 -: 2];

  always_comb begin
    stab_next = stab_reg;
    if (!sel_ok)                      stab_next = '0;
    else if (sync2_reg != prev_reg)   stab_next = 8'd1;
    else if (stab_reg != STAB_MAX)    stab_next = stab_reg + 8'd1;
  end

  assign fire = sel_ok && (stab_reg != STAB_MAX) && (stab_next == STAB_MAX);
  assign dec  = decode7seg(cap_seg_reg);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg     <= '0;
      sync2_reg     <= '0;
      prev_reg      <= '0;
      stab_reg      <= '0;
      cap_reg       <= 1'b0;
      cap_digit_reg <= 1'b0;
      cap_seg_reg   <= '0;
      cap_dp_reg    <= 1'b0;
      upd_reg       <= 1'b0;
      seg_err_reg   <= 1'b0;
      dp_out_reg    <= 1'b0;
    end else begin
      sync1_reg     <= {bus.en_in, bus.seg_in, bus.dp_in};
      sync2_reg     <= sync1_reg;
      prev_reg      <= sync2_reg;
      stab_reg      <= stab_next;
      // Capture is staged one cycle so decode sits on a registered pattern.
      cap_reg       <= fire;
      cap_digit_reg <= sync2_reg[WORD_W-1];
      cap_seg_reg   <= sync2_reg[SEG_W:1];
      cap_dp_reg    <= sync2_reg[0];
      upd_reg       <= cap_reg && dec[4];
      seg_err_reg   <= cap_reg && !dec[4];
      if (cap_reg && dec[4]) dp_out_reg <= cap_dp_reg;
    end
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_digit
      vslc_7seg_digit_track #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
      ) u_track (
        .clk    (clk),
        .rst_n  (rst_n),
        .cap    (cap_reg && (cap_digit_reg == 1'(gi))),
        .ok     (dec[4]),
        .nib_in (dec[3:0]),
        .nibble (nib_w[gi]),
        .valid  (valid_w[gi])
      );
    end
  endgenerate

  assign bus.value   = {nib_w[1], nib_w[0]};
  assign bus.valid   = {valid_w[1], valid_w[0]};
  assign bus.dp_out  = dp_out_reg;
  assign bus.upd     = upd_reg;
  assign bus.seg_err = seg_err_reg;
endmodule

// File: tb/tb_vslc_7seg_scan_rx.sv
// Bench for vslc_7seg_scan_rx: vector table, hand-written corner sequences
// and random dwell traffic against a run-length reference model.
module tb_vslc_7seg_scan_rx;
  localparam int S = 4;
  localparam int T = 1024;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vslc_7seg_scan_rx_if bus_if();

  vslc_7seg_scan_rx #(
    .STABLE_CYCLES  (S),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  int checks = 0;
  int errors = 0;

  logic [6:0] seg_tbl [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

  // Reference model: a digit word is read once its raw run length hits S,
  // and the result shows up three edges later (2 sync + 1 output stage).
  typedef struct { int edge_no; logic [9:0] w; } pend_t;
  pend_t      pq [$];
  int         ecnt;
  logic [9:0] last_w;
  int         run;
  logic [7:0] m_value;
  bit         m_vf [2];
  int         cap_edge [2];
  bit         m_dp, m_upd, m_err;
  int         upd_seen, err_seen;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int lookup(input logic [6:0] s);
    for (int i = 0; i < 16; i++) if (seg_tbl[i] == s) return i;
    return -1;
  endfunction

  task automatic model_reset();
    ecnt = 0; last_w = '0; run = 0; pq.delete();
    m_value = '0; m_vf[0] = 0; m_vf[1] = 0; cap_edge[0] = 0; cap_edge[1] = 0;
    m_dp = 0; m_upd = 0; m_err = 0;
  endtask

  task automatic drive(input logic [1:0] en, input logic [6:0] seg, input logic dp);
    bus_if.en_in = en; bus_if.seg_in = seg; bus_if.dp_in = dp;
  endtask

  task automatic tick();
    logic [9:0]  w;
    pend_t       p;
    int          k, idx;
    logic [1:0]  vexp;
    logic [12:0] exp_v, act_v;
    w = {bus_if.en_in, bus_if.seg_in, bus_if.dp_in};
    @(posedge clk);
    ecnt++; m_upd = 0; m_err = 0;
    run = (w == last_w) ? run + 1 : 1;
    last_w = w;
    if ((w[9:8] == 2'b01 || w[9:8] == 2'b10) && run == S) pq.push_back('{ecnt + 3, w});
    while (pq.size() > 0 && pq[0].edge_no == ecnt) begin
      p = pq.pop_front();
      k = (p.w[9:8] == 2'b10) ? 1 : 0;
      idx = lookup(p.w[7:1]);
      if (idx >= 0) begin
        if (k == 1) m_value[7:4] = 4'(idx); else m_value[3:0] = 4'(idx);
        m_vf[k] = 1; cap_edge[k] = ecnt; m_dp = p.w[0]; m_upd = 1;
      end else begin
        m_vf[k] = 0; m_err = 1;
      end
    end
    for (int j = 0; j < 2; j++) vexp[j] = m_vf[j] && ((ecnt - cap_edge[j]) < T);
    @(negedge clk);
    exp_v = {m_value, vexp, m_dp, m_upd, m_err};
    act_v = {bus_if.value, bus_if.valid, bus_if.dp_out, bus_if.upd, bus_if.seg_err};
    check($sformatf("model_cycle%0d", ecnt), 32'(act_v), 32'(exp_v));
    upd_seen += int'(bus_if.upd);
    err_seen += int'(bus_if.seg_err);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; drive(2'b00, 7'b0, 1'b0);
    repeat (2) @(negedge clk);
    model_reset();
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [1:0] en; logic [6:0] seg; logic dp; int hold;
    logic [7:0] value; logic [1:0] valid; logic dp_out; int n_upd; int n_err;
  } vec_t;
  vec_t vecs [8];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, r, hold, nib;
    logic [6:0] seg;

    vecs[0] = '{2'b01, 7'b1111001, 1'b0, 10, 8'h03, 2'b01, 1'b0, 1, 0};
    vecs[1] = '{2'b10, 7'b0111101, 1'b1, 10, 8'hD3, 2'b11, 1'b1, 1, 0};
    vecs[2] = '{2'b10, 7'b1010101, 1'b0, 10, 8'hD3, 2'b01, 1'b1, 0, 1};
    vecs[3] = '{2'b01, 7'b1110111, 1'b0,  3, 8'hD3, 2'b01, 1'b1, 0, 0};
    vecs[4] = '{2'b01, 7'b0110000, 1'b1,  8, 8'hD1, 2'b01, 1'b1, 1, 0};
    vecs[5] = '{2'b00, 7'b0000000, 1'b0,  5, 8'hD1, 2'b01, 1'b1, 0, 0};
    vecs[6] = '{2'b11, 7'b1111111, 1'b0,  5, 8'hD1, 2'b01, 1'b1, 0, 0};
    vecs[7] = '{2'b10, 7'b1011011, 1'b0,  8, 8'h51, 2'b11, 1'b0, 1, 0};

    // Reset state
    drive(2'b00, 7'b0, 1'b0);
    repeat (2) @(negedge clk);
    check("reset_outputs", 32'({bus_if.value, bus_if.valid, bus_if.dp_out, bus_if.upd, bus_if.seg_err}), 32'h0);

    // Vector table
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(vecs[i].en, vecs[i].seg, vecs[i].dp);
      upd_seen = 0; err_seen = 0;
      repeat (vecs[i].hold) tick();
      check($sformatf("vec%0d_value", i),  32'(bus_if.value),  32'(vecs[i].value));
      check($sformatf("vec%0d_valid", i),  32'(bus_if.valid),  32'(vecs[i].valid));
      check($sformatf("vec%0d_dp", i),     32'(bus_if.dp_out), 32'(vecs[i].dp_out));
      check($sformatf("vec%0d_upd", i),    32'(upd_seen),      32'(vecs[i].n_upd));
      check($sformatf("vec%0d_segerr", i), 32'(err_seen),      32'(vecs[i].n_err));
    end

    // Alternating 64-cycle dwell
    do_reset();
    for (int d = 0; d < 4; d++) begin
      if (d % 2 == 0) drive(2'b01, 7'b1110111, 1'b0);
      else            drive(2'b10, 7'b0111101, 1'b0);
      upd_seen = 0;
      repeat (64) tick();
      check($sformatf("dwell%0d_upd", d), 32'(upd_seen), 32'd1);
    end
    check("dwell_value", 32'(bus_if.value), 32'hDA);
    check("dwell_valid", 32'(bus_if.valid), 32'h3);

    // Reset three cycles into a stability window
    do_reset();
    drive(2'b01, 7'b1111111, 1'b1);
    repeat (10) tick();
    check("prerst_value", 32'(bus_if.value), 32'h08);
    drive(2'b01, 7'b1101101, 1'b0);
    repeat (3) tick();
    #2 rst_n = 1'b0;
    #1 check("midrst_outputs", 32'({bus_if.value, bus_if.valid, bus_if.dp_out, bus_if.upd, bus_if.seg_err}), 32'h0);
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    while (bus_if.upd !== 1'b1 && n < 20) begin tick(); n++; end
    check("rst_latency", 32'(n), 32'(S + 3));
    check("rst_value", 32'(bus_if.value), 32'h02);

    // Timeout of digit 0
    do_reset();
    drive(2'b01, 7'b1011011, 1'b0);
    n = 0;
    while (bus_if.upd !== 1'b1 && n < 20) begin tick(); n++; end
    check("to_capture", 32'(bus_if.upd), 32'd1);
    drive(2'b00, 7'b0, 1'b0);
    n = 0;
    while (bus_if.valid[0] === 1'b1 && n < T + 100) begin tick(); n++; end
    check("to_delay", 32'(n), 32'(T));
    check("to_value", 32'(bus_if.value), 32'h05);

    // Random dwell traffic against the model
    do_reset();
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 9);
      hold = $urandom_range(1, 10);
      nib = $urandom_range(0, 15);
      if (r < 7) begin
        drive(($urandom_range(0, 1) == 1) ? 2'b10 : 2'b01, seg_tbl[nib], 1'($urandom_range(0, 1)));
      end else if (r == 7) begin
        seg = 7'($urandom_range(0, 127));
        while (lookup(seg) >= 0) seg = 7'($urandom_range(0, 127));
        drive(($urandom_range(0, 1) == 1) ? 2'b10 : 2'b01, seg, 1'($urandom_range(0, 1)));
      end else begin
        drive(($urandom_range(0, 1) == 1) ? 2'b11 : 2'b00, 7'($urandom_range(0, 127)), 1'b0);
      end
      repeat (hold) tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
